// File: rtl/life_frame_controller.sv
// Raster timing generator and generation-step sequencer for the life PE array.
// Steps are only ever issued at vertical-blank start so the displayed frame never tears.
module life_frame_controller #(
  parameter int H_ACTIVE       = 1280,
  parameter int H_FP           = 48,
  parameter int H_SYNC         = 112,
  parameter int H_BP           = 248,
  parameter int V_ACTIVE       = 1024,
  parameter int V_FP           = 1,
  parameter int V_SYNC         = 3,
  parameter int V_BP           = 38,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step_req,
  input  logic        pe_done,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pe_step,
  output logic [15:0] gen_count,
  output logic        overrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] Y_PRE_VB = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_GEN - 1);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DONE = 1'b1;

  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic             pe_step_q, pe_step_d;
  logic [15:0]      gen_q, gen_d;
  logic             overrun_q, overrun_d;
  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             armed_q, armed_d;
  logic             pending_q, pending_d;

  logic xWrap, frameWrap, vblankStart, autoFire, issue;

  always_comb begin
    xWrap       = (x_q == X_LAST);
    frameWrap   = xWrap && (y_q == Y_LAST);
    vblankStart = xWrap && (y_q == Y_PRE_VB);

    x_d = xWrap ? 11'd0 : x_q + 11'd1;
    y_d = y_q;
    if (xWrap) y_d = frameWrap ? 11'd0 : y_q + 11'd1;

    // Sync/active are computed from the next coordinates so they line up with x/y.
    hsync_d  = (x_d >= HS_START) && (x_d < HS_END);
    vsync_d  = (y_d >= VS_START) && (y_d < VS_END);
    active_d = (x_d < X_VIS) && (y_d < Y_VIS);

    autoFire = vblankStart && run && (div_q == DIV_LAST);
    div_d    = div_q;
    if (vblankStart && run) div_d = autoFire ? '0 : div_q + DIV_W'(1);

    // A step armed while the array is still busy stays armed for a later vblank.
    issue     = vblankStart && (state_q == IDLE) && (armed_q || pending_q || autoFire);
    armed_d   = (armed_q || autoFire) && !issue;
    pending_d = (pending_q && !issue) || (step_req && !run);
    pe_step_d = issue;

    state_d   = state_q;
    gen_d     = gen_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT_DONE;
      end
      default: begin
        if (pe_done) begin
          state_d = IDLE;
          gen_d   = gen_q + 16'd1;
        end else if (frameWrap) begin
          overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      active_q  <= 1'b1;
      pe_step_q <= 1'b0;
      gen_q     <= '0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
      div_q     <= '0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      pe_step_q <= pe_step_d;
      gen_q     <= gen_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      div_q     <= div_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign active    = active_q;
  assign pe_step   = pe_step_q;
  assign gen_count = gen_q;
  assign overrun   = overrun_q;

endmodule
